bin2xs3_seq: RTL and testbench

//  Multi-digit binary-to-Excess-3 converter. Converts a BIN_W-bit unsigned value into

---
 rtl/b2xs3_pkg.sv | 24 ++
 rtl/xs3_digit_adj.sv | 15 +
 rtl/bin2xs3_seq.sv | 111 +++++++++++
 tb/tb_bin2xs3_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/b2xs3_pkg.sv
// Shared types and constants for the sequential binary-to-Excess-3 converter.
//   b2xs3_state_t : FSM state encoding
//   XS3_OFFSET    : offset turning a BCD digit into its Excess-3 code
//   DD_THRESH     : digit value at or above which double dabble adds DD_ADJ
//   DD_ADJ        : double dabble pre-shift correction
//   cnt_w()       : width of the iteration counter for a given binary width
package b2xs3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2xs3_state_t;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] DD_THRESH  = 4'd5;
  localparam logic [3:0] DD_ADJ     = 4'd3;

  // Counter must hold the value BIN_W itself, hence +1.
  function automatic int cnt_w(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/xs3_digit_adj.sv
// Double dabble digit correction: adds 3 to a BCD digit that is 5 or more so
// the following left shift carries correctly into the next digit.
// Arithmetic is 4-bit and wraps; no carry leaves the digit.
//   digit : BCD digit before correction
//   adj   : corrected digit
module xs3_digit_adj
  import b2xs3_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= DD_THRESH) ? (digit + DD_ADJ) : digit;

endmodule

// File: rtl/bin2xs3_seq.sv
// Sequential binary to Excess-3 converter (shift-and-add-3, one bit per clock).
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake; in_ready only in IDLE
//   bin                  : unsigned operand, sampled on the accepting edge
//   out_valid / out_ready: result handshake; result held while out_ready low
//   xs3                  : Excess-3 digits, digit k at [4k+3:4k]
//   ovf                  : operand >= 10^DIGITS; xs3 is then forced to zero
//   busy                 : conversion in progress
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// SHIFT | one double dabble iteration per clock, BIN_W iterations
// DONE  | result presented, waiting for out_ready
module bin2xs3_seq
  import b2xs3_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   xs3,
  output logic                  ovf,
  output logic                  busy
);

  localparam int CW = cnt_w(BIN_W);
  localparam int BW = 4 * DIGITS;

  b2xs3_state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [BIN_W-1:0] bin_reg, bin_sh;
  logic [BW-1:0]    bcd, bcd_adj, bcd_sh, xs3_nxt;
  logic             ovf_sticky, ovf_nxt;
  logic             last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    xs3_digit_adj u_adj (
      .digit (bcd[4*g +: 4]),
      .adj   (bcd_adj[4*g +: 4])
    );
    assign xs3_nxt[4*g +: 4] = bcd_sh[4*g +: 4] + XS3_OFFSET;
  end

  assign {bcd_sh, bin_sh} = {bcd_adj, bin_reg} << 1;
  // The bit leaving the top digit is a carry worth 10^DIGITS.
  assign ovf_nxt   = ovf_sticky | bcd_adj[BW-1];
  assign last_iter = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == SHIFT);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      bin_reg    <= '0;
      bcd        <= '0;
      ovf_sticky <= 1'b0;
      xs3        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_reg    <= bin;
            bcd        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CW'(BIN_W);
          end
        end
        SHIFT: begin
          bin_reg    <= bin_sh;
          bcd        <= bcd_sh;
          ovf_sticky <= ovf_nxt;
          cnt        <= cnt - CW'(1);
          // Final iteration: capture the result as the FSM enters DONE.
          if (last_iter) begin
            xs3 <= ovf_nxt ? '0 : xs3_nxt;
            ovf <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2xs3_seq.sv
module tb_bin2xs3_seq;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  out_ready_v;
  logic [15:0] bin;

  logic [11:0] xs3_a;
  logic [7:0]  xs3_b;
  logic [19:0] xs3_c;
  logic [2:0]  in_ready_v, out_valid_v, ovf_v, busy_v;
  logic [19:0] xs3_v [3];

  int bw_of [3] = '{8, 8, 16};
  int dg_of [3] = '{3, 2, 5};

  int n_checks = 0;
  int n_fail   = 0;

  bin2xs3_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .bin(bin[7:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .xs3(xs3_a), .ovf(ovf_v[0]), .busy(busy_v[0]));

  bin2xs3_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .bin(bin[7:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .xs3(xs3_b), .ovf(ovf_v[1]), .busy(busy_v[1]));

  bin2xs3_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .bin(bin), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .xs3(xs3_c), .ovf(ovf_v[2]), .busy(busy_v[2]));

  assign xs3_v[0] = {8'b0, xs3_a};
  assign xs3_v[1] = {12'b0, xs3_b};
  assign xs3_v[2] = xs3_c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: decimal digits by division, each plus 3; out of range -> zero + ovf.
  function automatic logic [19:0] ref_xs3(input int unsigned v, input int d, output logic o);
    int unsigned lim = 1;
    int unsigned rem = v;
    logic [19:0] r = '0;
    for (int i = 0; i < d; i++) lim = lim * 10;
    o = (v >= lim);
    if (o) return '0;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(rem % 10 + 3);
      rem = rem / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int k, input logic [15:0] v);
    bin = v;
    in_valid_v[k] = 1'b1;
    tick();
    in_valid_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out(input int k, input int hold);
    repeat (hold) tick();
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
  endtask

  task automatic convert(input int k, input logic [15:0] v, input int hold, input string tag);
    int lat;
    logic eo;
    logic [19:0] ex;
    ex = ref_xs3(int'(v), dg_of[k], eo);
    accept(k, v);
    wait_done(k, lat);
    chk({tag, "_latency"}, lat, bw_of[k]);
    chk({tag, "_xs3"}, {12'b0, xs3_v[k]}, {12'b0, ex});
    chk({tag, "_ovf"}, {31'b0, ovf_v[k]}, {31'b0, eo});
    release_out(k, hold);
    chk({tag, "_idle_ready"}, {31'b0, in_ready_v[k]}, 32'd1);
    chk({tag, "_idle_valid"}, {31'b0, out_valid_v[k]}, 32'd0);
  endtask

  initial begin
    int lat;
    logic eo;
    logic [19:0] ex;
    logic [15:0] v;

    rst_n = 1'b0;
    in_valid_v = '0;
    out_ready_v = '0;
    bin = '0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", {31'b0, in_ready_v[k]}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid_v[k]}, 32'd0);
      chk("rst_busy", {31'b0, busy_v[k]}, 32'd0);
      chk("rst_xs3", {12'b0, xs3_v[k]}, 32'd0);
      chk("rst_ovf", {31'b0, ovf_v[k]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // T1: zero, plus busy/in_ready during shifting
    accept(0, 16'd0);
    chk("t1_busy", {31'b0, busy_v[0]}, 32'd1);
    chk("t1_in_ready_busy", {31'b0, in_ready_v[0]}, 32'd0);
    wait_done(0, lat);
    chk("t1_latency", lat, 32'd8);
    chk("t1_xs3", {12'b0, xs3_v[0]}, 32'h333);
    chk("t1_ovf", {31'b0, ovf_v[0]}, 32'd0);
    chk("t1_busy_done", {31'b0, busy_v[0]}, 32'd0);
    release_out(0, 0);

    // T2
    convert(0, 16'd255, 1, "t2_255");
    chk("t2_255_const", {12'b0, xs3_v[0]}, 32'h588);
    convert(0, 16'd99, 0, "t2_99");
    chk("t2_99_const", {12'b0, xs3_v[0]}, 32'h3CC);

    // T3: two digits
    convert(1, 16'd100, 2, "t3_100");
    chk("t3_100_ovf_const", {31'b0, ovf_v[1]}, 32'd1);
    chk("t3_100_xs3_const", {12'b0, xs3_v[1]}, 32'h00);
    convert(1, 16'd99, 0, "t3_99");
    chk("t3_99_xs3_const", {12'b0, xs3_v[1]}, 32'hCC);

    // T4: backpressure with ignored in_valid pulses
    accept(0, 16'd173);
    wait_done(0, lat);
    chk("t4_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      in_valid_v[0] = i[0];
      bin = 16'($urandom_range(0, 255));
      tick();
      chk("t4_hold_xs3", {12'b0, xs3_v[0]}, 32'h4A6);
      chk("t4_hold_valid", {31'b0, out_valid_v[0]}, 32'd1);
      chk("t4_hold_in_ready", {31'b0, in_ready_v[0]}, 32'd0);
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    tick();
    out_ready_v[0] = 1'b0;
    chk("t4_rel_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    chk("t4_rel_valid", {31'b0, out_valid_v[0]}, 32'd0);
    chk("t4_rel_xs3_hold", {12'b0, xs3_v[0]}, 32'h4A6);
    tick();
    chk("t4_no_accept", {31'b0, busy_v[0]}, 32'd0);

    // T5: reset during iteration 4
    accept(0, 16'd200);
    repeat (3) tick();
    chk("t5_busy_before", {31'b0, busy_v[0]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {31'b0, out_valid_v[0]}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy_v[0]}, 32'd0);
    chk("t5_rst_xs3", {12'b0, xs3_v[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t5_in_ready", {31'b0, in_ready_v[0]}, 32'd1);
    convert(0, 16'd128, 1, "t5_after");

    // T6: wide instance
    convert(2, 16'd65535, 0, "t6_max");
    chk("t6_max_const", {12'b0, xs3_v[2]}, 32'h98868);
    for (int i = 0; i < 1000; i++) begin
      v = 16'($urandom_range(0, 65535));
      convert(2, v, $urandom_range(0, 3), "t6_rand");
    end
    // Random sweep on the two-digit instance to exercise the overflow path.
    for (int i = 0; i < 200; i++) begin
      v = 16'($urandom_range(0, 255));
      convert(1, v, $urandom_range(0, 2), "t6_rand2");
    end
    ex = ref_xs3(32'd7, 3, eo);
    convert(0, 16'd7, 0, "t6_small");
    chk("t6_small_model", {12'b0, xs3_v[0]}, {12'b0, ex});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
